// File: rtl/simd_alu_pkg.sv
// Shared opcode encoding and widths for the SIMD ALU pipeline.
// Imported by the lane datapath and the pipeline top.
package simd_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDS = 3'd2,
    OP_SUBS = 3'd3,
    OP_ACC  = 3'd4,
    OP_ACLR = 3'd5
  } op_e;

endpackage

// File: rtl/simd_alu_lane.sv
// One SIMD lane: combinational result/flag plus its own accumulator.
// The accumulator only moves when the top says the txn leaves stage 1.
module simd_alu_lane
  import simd_alu_pkg::*;
#(
  parameter int W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [OP_W-1:0] op_i,
  input  logic            en_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  input  logic            upd_i,
  output logic [W-1:0]    res_o,
  output logic            ovf_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W:0]   sum_w;
  logic [W:0]   dif_w;
  logic [W:0]   acs_w;

  // Lane op decode; W+1 bit sums expose carry/borrow in the MSB.
  always_comb begin
    sum_w = {1'b0, a_i} + {1'b0, b_i};
    dif_w = {1'b0, a_i} - {1'b0, b_i};
    acs_w = {1'b0, acc_q} + {1'b0, a_i};
    res_o = '0;
    ovf_o = 1'b0;
    acc_d = acc_q;
    if (en_i) begin
      case (op_i)
        OP_ADD: begin
          res_o = sum_w[W-1:0];
          ovf_o = sum_w[W];
        end
        OP_SUB: begin
          res_o = dif_w[W-1:0];
          ovf_o = dif_w[W];
        end
        OP_ADDS: begin
          res_o = sum_w[W] ? {W{1'b1}} : sum_w[W-1:0];
          ovf_o = sum_w[W];
        end
        OP_SUBS: begin
          res_o = dif_w[W] ? '0 : dif_w[W-1:0];
          ovf_o = dif_w[W];
        end
        OP_ACC: begin
          res_o = acs_w[W-1:0];
          ovf_o = acs_w[W];
          acc_d = acs_w[W-1:0];
        end
        OP_ACLR: begin
          res_o = a_i;
          acc_d = a_i;
        end
        default: begin
          res_o = '0;
          ovf_o = 1'b0;
        end
      endcase
    end
  end

  // Accumulator commits once per txn, in order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (upd_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage N-lane SIMD ALU with valid/ready on both sides.
// S1 holds operands, S2 holds results that drive the outputs.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [OP_W-1:0] op_i,
  input  logic [N-1:0]    lane_en_i,
  input  logic [W-1:0]    a_i [N-1:0],
  input  logic [W-1:0]    b_i [N-1:0],
  output logic            valid_o,
  input  logic            ready_i,
  output logic [W-1:0]    res_o [N-1:0],
  output logic [N-1:0]    ovf_o
);

  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  logic [OP_W-1:0] op1_q, op1_d;
  logic [N-1:0]    en1_q, en1_d;
  logic [W-1:0]    a1_q [N-1:0];
  logic [W-1:0]    a1_d [N-1:0];
  logic [W-1:0]    b1_q [N-1:0];
  logic [W-1:0]    b1_d [N-1:0];
  logic [W-1:0]    res_q [N-1:0];
  logic [W-1:0]    res_d [N-1:0];
  logic [N-1:0]    ovf_q, ovf_d;
  logic [W-1:0]    lres [N-1:0];
  logic [N-1:0]    lovf;
  logic            adv1;
  logic            adv2;
  logic            load1;
  logic            load2;

  // Handshake chain and next-state for both stages.
  always_comb begin
    adv2  = !v2_q | ready_i;
    adv1  = !v1_q | adv2;
    load1 = valid_i & adv1;
    load2 = v1_q & adv2;
    v1_d  = adv1 ? valid_i : v1_q;
    v2_d  = adv2 ? v1_q : v2_q;
    op1_d = load1 ? op_i : op1_q;
    en1_d = load1 ? lane_en_i : en1_q;
    ovf_d = load2 ? lovf : ovf_q;
    for (int i = 0; i < N; i++) begin
      a1_d[i]  = load1 ? a_i[i] : a1_q[i];
      b1_d[i]  = load1 ? b_i[i] : b1_q[i];
      res_d[i] = load2 ? lres[i] : res_q[i];
    end
  end

  // Stage registers; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      op1_q <= '0;
      en1_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < N; i++) begin
        a1_q[i]  <= '0;
        b1_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      op1_q <= op1_d;
      en1_q <= en1_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < N; i++) begin
        a1_q[i]  <= a1_d[i];
        b1_q[i]  <= b1_d[i];
        res_q[i] <= res_d[i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    simd_alu_lane #(
      .W(W)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .op_i   (op1_q),
      .en_i   (en1_q[g]),
      .a_i    (a1_q[g]),
      .b_i    (b1_q[g]),
      .upd_i  (load2),
      .res_o  (lres[g]),
      .ovf_o  (lovf[g])
    );
  end

  assign ready_o = adv1;
  assign valid_o = v2_q;
  assign res_o   = res_q;
  assign ovf_o   = ovf_q;

endmodule
